exec_seq_ctrl: RTL
==================

Name: exec_seq_ctrl

Overview:
Multi-cycle sequencer for the non-pipelined core. Owns the PC and steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It drives the instruction/data memory request handshakes, the execution-stage enable and the register-file write strobe. It resolves the next PC from the execution stage's branch decision and target, and detects memory timeouts and misaligned branch targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 16, max wait cycles for imem_ready/dmem_ready before fault (>=1)
CNT_W, 8, width of wait counter (2^CNT_W > MEM_TIMEOUT)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  enable instruction issue
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete this cycle
is_load  in  1  decoded load, valid in EXECUTE
is_store  in  1  decoded store, valid in EXECUTE
reg_write  in  1  decoded rd write, valid in EXECUTE
halt_req  in  1  decoded ecall/ebreak, valid in EXECUTE
is_branch_out  in  1  taken-branch flag from execution stage
branch_result  in  32  branch target from execution stage
pc  out  32  current instruction address
imem_req  out  1  instruction fetch request
ir_load  out  1  latch instruction register
ex_en  out  1  execution stage operands/result valid
dmem_req  out  1  data memory request
dmem_we  out  1  data write (store)
rf_we  out  1  register-file write strobe
instret  out  32  retired instruction count
halted  out  1  core halted (sticky)
fault  out  1  timeout or misaligned target (sticky)
state_o  out  3  IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEM=4 WB=5 HALT=6 FAULT=7

Behaviour:
- Reset (rst=0, async): state IDLE; pc=RESET_PC; instret=0; halted=0; fault=0. All strobes 0 and internal latches cleared. Reset mid-instruction aborts it with no rf_we and no pc update.
- Strobes are combinational decodes of state and registered latches only:
  - imem_req = FETCH
  - ir_load = FETCH & imem_ready
  - ex_en = EXECUTE
  - dmem_req = MEM
  - dmem_we = MEM & st_q
  - rf_we = WB & rw_q
  - halted = HALT
  - fault = FAULT
- IDLE: run=1 -> FETCH next cycle, else stay.
- FETCH: imem_req held until imem_ready=1 -> DECODE. The wait counter is cleared on entry and increments each cycle without ready. Counter == MEM_TIMEOUT with no ready -> FAULT. Ready in the same cycle as the timeout: ready wins.
- DECODE: exactly 1 cycle -> EXECUTE.
- EXECUTE: exactly 1 cycle. Latches:
  - ld_q=is_load, st_q=is_store, rw_q=reg_write, hlt_q=halt_req
  - next_pc = is_branch_out ? branch_result : pc+4 (mod 2^32)
- EXECUTE transitions, in priority order:
  - is_branch_out=1 with branch_result[1:0]!=0 -> FAULT, no retire.
  - is_load|is_store -> MEM (if both are asserted, the store is taken).
  - Otherwise -> WB.
- MEM: dmem_req held until dmem_ready=1 -> WB. Same timeout rule as FETCH, with the counter cleared on entry.
- WB: exactly 1 cycle.
  - pc <= next_pc; instret <= instret+1 (wraps modulo 2^32).
  - Next state: hlt_q -> HALT; else run -> FETCH; else IDLE.
- run deasserted mid-instruction: the current instruction completes through WB, then IDLE. run is only sampled in IDLE and WB.
- HALT and FAULT are terminal until reset; pc and instret are frozen.
- Latency: non-memory instruction = fetch wait + 4 cycles (FETCH, DECODE, EXECUTE, WB) with zero-wait imem. Load/store adds MEM (>=1 cycle).
- pc changes only on the WB clock edge.

Test Plan:
- Reset/ALU op: rst low then high, run=1, imem_ready=1 always, no load/store/branch -> state 1,2,3,5 repeating; pc 0,4,8 each 4 cycles; instret increments at each WB; rf_we follows reg_write for one cycle.
- Taken branch: pc=0x10, is_branch_out=1, branch_result=0x40 in EXECUTE -> pc=0x40 after WB. Not-taken case -> pc=0x14.
- Load with waits: is_load=1, dmem_ready asserted on the 3rd MEM cycle -> dmem_req high 3 cycles, dmem_we=0, then WB. Store -> dmem_we=1 during MEM.
- Timeout: imem_ready=0 for MEM_TIMEOUT+1 cycles -> FAULT, fault=1 and held, pc unchanged. Ready arriving on the timeout cycle -> DECODE, no fault.
- Misaligned branch: branch_result=0x42 taken -> FAULT after EXECUTE; instret unchanged.
- Halt and run drop: halt_req=1 -> HALT after WB, halted=1, instret incremented once. run dropped during MEM -> instruction retires, then IDLE. Async reset asserted during MEM -> immediate IDLE, pc=RESET_PC, no rf_we.

Source files
------------

// File: rtl/exec_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns the PC, steps FETCH/DECODE/EXECUTE/MEM/WB,
// drives memory handshakes and retire strobes, and traps memory timeouts and misaligned targets.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | waiting for run
//   FETCH   | imem request outstanding
//   DECODE  | instruction register settling into decode
//   EXECUTE | execution stage valid; decode flags and next pc latched
//   MEM     | dmem request outstanding
//   WB      | retire: rf write, pc update, instret increment
//   HALT    | ecall/ebreak retired; terminal until reset
//   FAULT   | timeout or misaligned branch target; terminal until reset
module exec_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        reg_write,
  input  logic        halt_req,
  input  logic        is_branch_out,
  input  logic [31:0] branch_result,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        ir_load,
  output logic        ex_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [31:0] instret,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instret_q, instret_d;
  logic [31:0]      next_pc_q, next_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             st_q, st_d;
  logic             rw_q, rw_d;
  logic             hlt_q, hlt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instret_q <= '0;
      next_pc_q <= '0;
      cnt_q     <= '0;
      st_q      <= 1'b0;
      rw_q      <= 1'b0;
      hlt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      next_pc_q <= next_pc_d;
      cnt_q     <= cnt_d;
      st_q      <= st_d;
      rw_q      <= rw_d;
      hlt_q     <= hlt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    next_pc_d = next_pc_q;
    cnt_d     = cnt_q;
    st_d      = st_q;
    rw_d      = rw_q;
    hlt_d     = hlt_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        // a ready arriving on the timeout cycle still completes the fetch
        if (imem_ready)        state_d = S_DECODE;
        else if (cnt_q == TMO) state_d = S_FAULT;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        st_d      = is_store;
        rw_d      = reg_write;
        hlt_d     = halt_req;
        next_pc_d = is_branch_out ? branch_result : pc_q + 32'd4;
        if (is_branch_out && (branch_result[1:0] != 2'b00)) begin
          state_d = S_FAULT;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready)        state_d = S_WB;
        else if (cnt_q == TMO) state_d = S_FAULT;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_WB: begin
        pc_d      = next_pc_q;
        instret_d = instret_q + 32'd1;
        if (hlt_q) begin
          state_d = S_HALT;
        end else if (run) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  assign pc       = pc_q;
  assign instret  = instret_q;
  assign state_o  = state_q;
  assign imem_req = (state_q == S_FETCH);
  assign ir_load  = (state_q == S_FETCH) && imem_ready;
  assign ex_en    = (state_q == S_EXEC);
  assign dmem_req = (state_q == S_MEM);
  assign dmem_we  = (state_q == S_MEM) && st_q;
  assign rf_we    = (state_q == S_WB) && rw_q;
  assign halted   = (state_q == S_HALT);
  assign fault    = (state_q == S_FAULT);

endmodule
